framebuffer_reader: RTL and testbench

- Reader end of the pixel framebuffer. The raytracing controller writes pixels into the pixel BRAM; this block walks the buffer in raster order and emits one (x, y, value) beat per pixel on a valid/ready stream.
- Intended consumers are a frame-dump link such as a UART or debug streamer, and frame-compare logic.
- Lives in the sys_clk domain and drives the pixel BRAM port A address while the controller is idle.

---
 rtl/framebuffer_reader_if.sv | 13 +
 rtl/framebuffer_reader.sv | 98 +++++++++
 tb/tb_framebuffer_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/framebuffer_reader_if.sv
// framebuffer_reader_if: pixel beat stream carrying raster coordinates and pixel word
interface framebuffer_reader_if #(
   parameter int COORD_BITS = 16,
   parameter int PIXEL_BITS = 16
);
   logic valid_out;
   logic ready_in;
   logic [COORD_BITS-1:0] pixel_x_out;
   logic [COORD_BITS-1:0] pixel_y_out;
   logic [PIXEL_BITS-1:0] pixel_value;
   modport master(output valid_out, pixel_x_out, pixel_y_out, pixel_value, input ready_in);
   modport slave(input valid_out, pixel_x_out, pixel_y_out, pixel_value, output ready_in);
endinterface

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: walks the pixel BRAM in raster order and streams (x, y, value) beats
module framebuffer_reader #(
   parameter int FRAME_WIDTH  = 512,
   parameter int FRAME_HEIGHT = 384,
   parameter int ADDR_BITS    = 18,
   parameter int PIXEL_BITS   = 16,
   parameter int COORD_BITS   = 16,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic                  mem_en,
   input  logic [PIXEL_BITS-1:0] mem_data,
   framebuffer_reader_if.master  s
);
   localparam int XB = $clog2(FRAME_WIDTH);
   localparam int YB = $clog2(FRAME_HEIGHT + 1);
   localparam int PB = $clog2(FIFO_DEPTH);
   localparam int CB = $clog2(FIFO_DEPTH + 1) + 1;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state, state_n;
   logic [XB-1:0] rd_x;
   logic [YB-1:0] rd_y;
   logic [READ_LATENCY-1:0] tag;
   logic [XB-1:0] tx [READ_LATENCY];
   logic [YB-1:0] ty [READ_LATENCY];
   logic [XB-1:0] fx [FIFO_DEPTH];
   logic [YB-1:0] fy [FIFO_DEPTH];
   logic [PIXEL_BITS-1:0] fv [FIFO_DEPTH];
   logic [PB-1:0] wp, rp;
   logic [CB-1:0] count, inflight;
   logic push, pop, last_rd, last_pop;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CB'(tag[i]);
   end
   // Reserving FIFO room for every in-flight read makes overflow impossible
   assign mem_en = state == READ && (count + inflight) < CB'(FIFO_DEPTH);
   assign mem_addr = ADDR_BITS'({rd_y, rd_x});
   assign last_rd = rd_x == XB'(FRAME_WIDTH - 1) && rd_y == YB'(FRAME_HEIGHT - 1);
   assign push = tag[READ_LATENCY-1];
   assign pop = s.valid_out && s.ready_in;
   assign last_pop = state == DRAIN && pop && count == CB'(1) && inflight == '0;
   assign busy = state != IDLE;
   assign s.valid_out = count != '0;
   assign s.pixel_x_out = s.valid_out ? COORD_BITS'(fx[rp]) : '0;
   assign s.pixel_y_out = s.valid_out ? COORD_BITS'(fy[rp]) : '0;
   assign s.pixel_value = s.valid_out ? fv[rp] : '0;
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (start ? READ : IDLE) :
                state == READ ? (mem_en && last_rd ? DRAIN : READ) :
                (last_pop ? IDLE : DRAIN);
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         tag   <= '0;
         count <= '0;
         wp    <= '0;
         rp    <= '0;
         done  <= 1'b0;
         rd_x  <= '0;
         rd_y  <= '0;
      end else begin
         done  <= last_pop;
         tag   <= READ_LATENCY'({tag, mem_en});
         count <= count + CB'(push) - CB'(pop);
         if (state == IDLE && start) begin
            rd_x <= '0;
            rd_y <= '0;
         end else if (mem_en) begin
            rd_x <= rd_x + XB'(1);
            rd_y <= rd_y + YB'(rd_x == XB'(FRAME_WIDTH - 1));
         end
         if (push) wp <= wp == PB'(FIFO_DEPTH - 1) ? '0 : wp + PB'(1);
         if (pop) rp <= rp == PB'(FIFO_DEPTH - 1) ? '0 : rp + PB'(1);
      end
   end
   always_ff @(posedge clk) begin
      tx[0] <= rd_x;
      ty[0] <= rd_y;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tx[i] <= tx[i-1];
         ty[i] <= ty[i-1];
      end
      if (push) begin
         fx[wp] <= tx[READ_LATENCY-1];
         fy[wp] <= ty[READ_LATENCY-1];
         fv[wp] <= mem_data;
      end
   end
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: directed checks of a 4x2 frame read against a BRAM model mem[a]=a+0x100
module tb_framebuffer_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, mem_en;
   logic [17:0] mem_addr;
   logic [15:0] mem_data, r1, r2;
   int checks = 0, errors = 0, done_cnt = 0, en_cnt = 0, beats_at_done = 0, cyc = 0;
   logic [47:0] beats [$];
   framebuffer_reader_if #(.COORD_BITS(16), .PIXEL_BITS(16)) s();
   framebuffer_reader #(
      .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .ADDR_BITS(18), .PIXEL_BITS(16),
      .COORD_BITS(16), .READ_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data), .s(s)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_en) r1 <= 16'h100 + mem_addr[15:0];
      r2 <= r1;
   end
   assign mem_data = r2;
   always @(negedge clk) begin
      if (s.valid_out && s.ready_in) beats.push_back({s.pixel_x_out, s.pixel_y_out, s.pixel_value});
      if (mem_en) en_cnt++;
      if (done) begin
         done_cnt++;
         beats_at_done = beats.size();
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pulse_start;
      beats.delete();
      done_cnt = 0;
      en_cnt = 0;
      beats_at_done = 0;
      start = 1'b1;
      cyc = 0;
      tick;
      start = 1'b0;
   endtask
   task automatic wait_done(input bit alt);
      for (int k = 0; k < 100 && !done; k++) begin
         if (alt) s.ready_in = ~s.ready_in;
         tick;
      end
      check("done_seen", 48'(done), 48'd1);
      check("busy_at_done", 48'(busy), 48'd0);
   endtask
   task automatic wait_beats(input int n);
      for (int k = 0; k < 100 && beats.size() < n; k++) tick;
      check("beats_reached", 48'(beats.size()), 48'(n));
   endtask
   task automatic finish_frame(input string tag);
      s.ready_in = 1'b1;
      tick;
      tick;
      check({tag, "_done_count"}, 48'(done_cnt), 48'd1);
      check({tag, "_beats_at_done"}, 48'(beats_at_done), 48'd8);
      check({tag, "_beat_count"}, 48'(beats.size()), 48'd8);
      for (int i = 0; i < 8; i++)
         check({tag, "_beat"}, (i < beats.size()) ? beats[i] : 48'hx,
               {16'(i % 4), 16'(i / 4), 16'(16'h100 + i)});
   endtask
   initial begin
      s.ready_in = 1'b1;
      tick;
      tick;
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_done", 48'(done), 48'd0);
      check("rst_valid", 48'(s.valid_out), 48'd0);
      check("rst_mem_en", 48'(mem_en), 48'd0);
      check("rst_mem_addr", 48'(mem_addr), 48'd0);
      check("rst_pixel", {s.pixel_x_out, s.pixel_y_out, s.pixel_value}, 48'd0);
      rst = 1'b0;
      tick;
      pulse_start;
      check("t1_busy", 48'(busy), 48'd1);
      tick;
      tick;
      check("t1_valid_early", 48'(s.valid_out), 48'd0);
      tick;
      check("t1_valid_first", 48'(s.valid_out), 48'd1);
      check("t1_first_beat", {s.pixel_x_out, s.pixel_y_out, s.pixel_value}, {16'd0, 16'd0, 16'h100});
      wait_done(1'b0);
      check("t1_done_latency", 48'(cyc), 48'd12);
      finish_frame("t1");
      s.ready_in = 1'b0;
      pulse_start;
      for (int k = 0; k < 9; k++) begin
         tick;
         if (k >= 3) check("t2_hold", {47'd0, s.valid_out, s.pixel_value}, {47'd1, 16'h100});
      end
      check("t2_head", {s.pixel_x_out, s.pixel_y_out, s.pixel_value}, {16'd0, 16'd0, 16'h100});
      check("t2_outstanding", 48'(en_cnt), 48'd4);
      s.ready_in = 1'b1;
      wait_done(1'b0);
      finish_frame("t2");
      s.ready_in = 1'b1;
      pulse_start;
      wait_done(1'b1);
      finish_frame("t3");
      pulse_start;
      wait_beats(2);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("t4_busy", 48'(busy), 48'd1);
      wait_done(1'b0);
      finish_frame("t4");
      pulse_start;
      wait_beats(4);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("t5_valid", 48'(s.valid_out), 48'd0);
      check("t5_busy", 48'(busy), 48'd0);
      check("t5_mem_en", 48'(mem_en), 48'd0);
      repeat (4) tick;
      check("t5_stale_ignored", 48'(s.valid_out), 48'd0);
      check("t5_no_done", 48'(done_cnt), 48'd0);
      pulse_start;
      tick;
      tick;
      tick;
      check("t5_first_beat", {47'd0, s.valid_out}, 48'd1);
      check("t5_first_xyv", {s.pixel_x_out, s.pixel_y_out, s.pixel_value}, {16'd0, 16'd0, 16'h100});
      wait_done(1'b0);
      finish_frame("t5");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
